// File: rtl/program_counter_if.sv
// program_counter_if -- signal bundle for the program-counter datapath.
//   pc         : current program counter (from PC block)
//   pc_plus4   : pc + 4 (from PC block)
//   pc_target  : branch / JAL target (to PC block)
//   alu_result : JALR target (to PC block)
//   pc_src     : next-PC select (to PC block)
// The master modport is the side that drives the selects and targets.
// The slave modport is the PC block itself.
interface program_counter_if;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_target;
  logic [31:0] alu_result;
  logic [1:0]  pc_src;

  modport master (
    output pc_target, alu_result, pc_src,
    input  pc, pc_plus4
  );

  modport slave (
    input  pc_target, alu_result, pc_src,
    output pc, pc_plus4
  );
endinterface

// File: rtl/program_counter.sv
// program_counter -- registered RISC-V style program counter.
//   PC        out 32 : current PC, registered on CLK rising edge
//   PCPlus4   out 32 : PC + 4, combinational (wraps modulo 2^32)
//   PCTarget  in  32 : branch / JAL target, loaded when PCSrc = 01
//   ALUResult in  32 : JALR target, loaded when PCSrc = 10
//   PCSrc     in  2  : 00 / 11 sequential, 01 target, 10 ALU result
//   Reset     in  1  : synchronous active-high, loads RESET_VECTOR
//   CLK       in  1  : clock
// Targets are loaded unmodified; no alignment masking is applied.
module program_counter #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  input  logic [31:0] PCTarget,
  input  logic [31:0] ALUResult,
  input  logic [1:0]  PCSrc,
  input  logic        Reset,
  input  logic        CLK
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_next;

  // Natural 32-bit overflow gives the wrap from FFFF_FFFC to 0.
  assign w_pc_plus4 = r_pc + 32'd4;

  always_comb begin
    w_pc_next = w_pc_plus4;
    case (PCSrc)
      2'b01:   w_pc_next = PCTarget;
      2'b10:   w_pc_next = ALUResult;
      default: w_pc_next = w_pc_plus4;  // 00 and the 11 fallback
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_pc <= RESET_VECTOR;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign PC      = r_pc;
  assign PCPlus4 = w_pc_plus4;

endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter -- directed and randomized checks of program_counter
// against an arithmetic reference model of the next-PC rules.
module tb_program_counter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [31:0] exp_pc;

  program_counter_if bus ();

  program_counter #(.RESET_VECTOR(32'h0000_0000)) dut (
    .PC        (bus.pc),
    .PCPlus4   (bus.pc_plus4),
    .PCTarget  (bus.pc_target),
    .ALUResult (bus.alu_result),
    .PCSrc     (bus.pc_src),
    .Reset     (rst),
    .CLK       (clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: what the PC should become at the next edge given the
  // current PC and the inputs present at that edge.
  function automatic logic [31:0] model_next(input logic reset_in, input logic [1:0] src,
                                             input logic [31:0] pc, input logic [31:0] tgt,
                                             input logic [31:0] alu);
    longint unsigned seq;
    seq = (longint'(pc) + 4) % 64'h1_0000_0000;
    if (reset_in)        return 32'h0000_0000;
    if (src == 2'd1)     return tgt;
    if (src == 2'd2)     return alu;
    return seq[31:0];
  endfunction

  // Advance one edge, update the model, then check both outputs.
  task automatic tick(input string tag);
    logic [31:0] seq;
    exp_pc = model_next(rst, bus.pc_src, exp_pc, bus.pc_target, bus.alu_result);
    @(posedge clk);
    #1;
    seq = exp_pc + 32'd4;
    check_val({tag, ".pc"}, bus.pc, exp_pc);
    check_val({tag, ".pc4"}, bus.pc_plus4, seq);
    $display("txn %-12s rst=%0b src=%0d pc=0x%08h pc4=0x%08h",
             tag, rst, bus.pc_src, bus.pc, bus.pc_plus4);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_pc   = 32'h0;
    rst      = 1'b1;
    bus.pc_src     = 2'b00;
    bus.pc_target  = 32'h0;
    bus.alu_result = 32'h0;
    @(negedge clk);

    // Reset state
    tick("reset");
    rst = 1'b0;
    // Sequential run
    for (int i = 0; i < 3; i++) tick("seq");
    // Branch target held for two edges
    bus.pc_src = 2'b01; bus.pc_target = 32'h0000_0100;
    tick("tgt1"); tick("tgt2");
    // JALR target then sequential
    bus.pc_src = 2'b10; bus.alu_result = 32'h0000_0200;
    tick("alu1"); tick("alu2");
    bus.pc_src = 2'b00;
    tick("seq_a"); tick("seq_b");
    // Odd target passes unmasked
    bus.pc_src = 2'b01; bus.pc_target = 32'h1234_5677;
    tick("odd_tgt");
    // Wrap at top of address space
    bus.pc_target = 32'hFFFF_FFFC;
    tick("top");
    bus.pc_src = 2'b00;
    tick("wrap");
    // Fallback select 11 behaves as sequential
    bus.pc_src = 2'b11; bus.pc_target = 32'hDEAD_BEE0; bus.alu_result = 32'hCAFE_0000;
    tick("src11");
    // Reset during a branch select discards the branch
    bus.pc_src = 2'b01; bus.pc_target = 32'h0000_0100;
    tick("pre_rst");
    rst = 1'b1;
    tick("rst_branch");
    rst = 1'b0;
    // Mid-cycle changes must not move PC until the edge
    bus.pc_src = 2'b00;
    tick("post_rst");
    #2;
    rst = 1'b1;
    bus.pc_src = 2'b10; bus.alu_result = 32'h0000_0ABC;
    #1;
    check_val("mid_rst.pc", bus.pc, exp_pc);
    rst = 1'b0;
    bus.pc_src = 2'b01; bus.pc_target = 32'h0000_0F00;
    #1;
    check_val("mid_in.pc", bus.pc, exp_pc);
    tick("after_mid");

    // Randomized run against the model
    for (int i = 0; i < 200; i++) begin
      bus.pc_src     = 2'($urandom_range(0, 3));
      bus.pc_target  = $urandom;
      bus.alu_result = $urandom;
      rst            = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) bus.pc_target = 32'hFFFF_FFFC;
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
